// File: rtl/any1_pkg.sv
// Shared types for the ANY-1 memory-operation sequencer.
package any1_pkg;

  localparam int NELEM = 64;
  localparam int STEPW = 6;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    AGEN  = 3'd1,
    REQ   = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } MemSeqState;

  typedef enum logic [1:0] {
    MSK_SCALAR = 2'd0,
    MSK_VECTOR = 2'd1,
    MSK_MULTI  = 2'd2
  } MemSeqKind;

  // Reduce the incoming mask to the elements an operation will actually touch.
  function automatic logic [NELEM-1:0] eff_mask(input logic [1:0] kind,
                                                input logic [6:0] vl,
                                                input logic [NELEM-1:0] mask);
    logic [NELEM-1:0] len_mask;
    len_mask = (vl >= 7'd64) ? '1 : ((64'd1 << vl) - 64'd1);
    case (kind)
      MSK_SCALAR: eff_mask = 64'd1;
      MSK_VECTOR: eff_mask = mask & len_mask;
      default:    eff_mask = mask;
    endcase
  endfunction

endpackage

// File: rtl/any1_ffo64.sv
// Combinational find-first-one over a 64-bit vector (lowest set bit wins).
module any1_ffo64
  import any1_pkg::*;
(
  input  logic [NELEM-1:0] vec,
  output logic [STEPW-1:0] idx,
  output logic             none
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx  = '0;
    none = 1'b1;
    for (int i = NELEM - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx  = STEPW'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/any1_mem_seq.sv
// Memory-operation sequencer: walks the active elements of a load/store and
// issues one req/ack memory transaction per element.
module any1_mem_seq
  import any1_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       kind,
  input  logic             is_store,
  input  logic [6:0]       vl,
  input  logic [NELEM-1:0] mask,
  input  logic             kill,
  output logic [STEPW-1:0] step,
  output logic [STEPW-1:0] ord,
  output logic             mem_req,
  output logic             mem_we,
  input  logic             mem_ack,
  input  logic             mem_fault,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [STEPW-1:0] fault_step
);

  MemSeqState       state;
  logic [NELEM-1:0] act_mask;
  logic             we_lat;
  logic             kill_pend;

  logic [NELEM-1:0] eff_in;
  logic [NELEM-1:0] next_vec;
  logic [STEPW-1:0] first_idx;
  logic             first_none;
  logic [STEPW-1:0] next_idx;
  logic             next_none;

  assign eff_in = eff_mask(kind, vl, mask);

  // Shifting 2 by step clears every element up to and including the current one;
  // at step 63 the shift overflows to zero, leaving no candidates.
  assign next_vec = act_mask & ~((64'd2 << step) - 64'd1);

  any1_ffo64 u_ffo_first (
    .vec  (eff_in),
    .idx  (first_idx),
    .none (first_none)
  );

  any1_ffo64 u_ffo_next (
    .vec  (next_vec),
    .idx  (next_idx),
    .none (next_none)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      act_mask   <= '0;
      we_lat     <= 1'b0;
      kill_pend  <= 1'b0;
      step       <= '0;
      ord        <= '0;
      fault_step <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !kill) begin
            act_mask  <= eff_in;
            we_lat    <= is_store;
            kill_pend <= 1'b0;
            ord       <= '0;
            if (first_none) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              step  <= first_idx;
              state <= AGEN;
            end
          end
        end
        AGEN: begin
          if (kill) begin
            state <= IDLE;
          end else begin
            state   <= REQ;
            mem_req <= 1'b1;
            mem_we  <= we_lat;
          end
        end
        REQ: begin
          // The request is never withdrawn early; a kill only takes effect at ack.
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (mem_fault) fault_step <= step;
            if (kill || kill_pend) begin
              state     <= IDLE;
              kill_pend <= 1'b0;
            end else if (mem_fault) begin
              state <= FAULT;
              fault <= 1'b1;
            end else begin
              ord <= ord + 1'b1;
              if (next_none) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                step  <= next_idx;
                state <= AGEN;
              end
            end
          end else if (kill) begin
            kill_pend <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_any1_mem_seq.sv
// Bench for any1_mem_seq: a per-cycle timeline model built from the element list.
module tb_any1_mem_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  kind;
  logic        is_store;
  logic [6:0]  vl;
  logic [63:0] mask;
  logic        kill;
  logic [5:0]  step;
  logic [5:0]  ord;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack;
  logic        mem_fault;
  logic        busy;
  logic        done;
  logic        fault;
  logic [5:0]  fault_step;

  any1_mem_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .kind       (kind),
    .is_store   (is_store),
    .vl         (vl),
    .mask       (mask),
    .kill       (kill),
    .step       (step),
    .ord        (ord),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_ack    (mem_ack),
    .mem_fault  (mem_fault),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .fault_step (fault_step)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st_in, ack_in, flt_in, kill_in;
    logic       req, we, bsy, dn, ft;
    logic [5:0] stp, od, fs;
  } cyc_t;

  cyc_t tl[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;

  logic [5:0] m_step = '0;
  logic [5:0] m_ord  = '0;
  logic [5:0] m_fs   = '0;

  int   done_cyc, fault_cyc, req_cnt, we_cnt;
  int   req_steps[$];
  logic prev_req;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cyc_t mk(input logic req, input logic we, input logic bsy,
                              input logic dn, input logic ft);
    cyc_t c;
    c.st_in = 0; c.ack_in = 0; c.flt_in = 0; c.kill_in = 0;
    c.req = req; c.we = we; c.bsy = bsy; c.dn = dn; c.ft = ft;
    c.stp = m_step; c.od = m_ord; c.fs = m_fs;
    return c;
  endfunction

  // Build the expected cycle-by-cycle timeline from the list of active elements.
  task automatic build_op(input int k, input bit we, input int vlen, input logic [63:0] m,
                          input int waits, input int fault_k, input int kill_k);
    int   elems[$];
    cyc_t c;
    bit   ended;
    tl.delete();
    for (int i = 0; i < 64; i++) begin
      if (k == 0) begin
        if (i == 0) elems.push_back(i);
      end else if (k == 1) begin
        if (i < vlen && m[i]) elems.push_back(i);
      end else if (m[i]) begin
        elems.push_back(i);
      end
    end
    c = mk(0, 0, 0, 0, 0);
    c.st_in = 1;
    tl.push_back(c);
    m_ord = 0;
    ended = 0;
    for (int e = 0; e < elems.size() && !ended; e++) begin
      m_step = elems[e][5:0];
      tl.push_back(mk(0, 0, 1, 0, 0));
      for (int w = 0; w <= waits; w++) begin
        c = mk(1, we, 1, 0, 0);
        c.ack_in  = (w == waits);
        c.flt_in  = (w == waits) && (e == fault_k);
        c.kill_in = (w == 0) && (e == kill_k);
        tl.push_back(c);
      end
      if (e == kill_k) begin
        if (e == fault_k) m_fs = m_step;
        ended = 1;
      end else if (e == fault_k) begin
        m_fs = m_step;
        tl.push_back(mk(0, 0, 1, 0, 1));
        ended = 1;
      end else begin
        m_ord = m_ord + 1;
      end
    end
    if (!ended) tl.push_back(mk(0, 0, 1, 1, 0));
    tl.push_back(mk(0, 0, 0, 0, 0));
    tl.push_back(mk(0, 0, 0, 0, 0));
  endtask

  task automatic apply_stimulus(input int k, input bit we, input int vlen, input logic [63:0] m);
    done_cyc = -1; fault_cyc = -1; req_cnt = 0; we_cnt = 0;
    req_steps.delete();
    prev_req = 0;
    kind = k[1:0]; is_store = we; vl = vlen[6:0]; mask = m;
    for (int c = 0; c < tl.size(); c++) begin
      @(posedge clk);
      #1;
      start     = tl[c].st_in;
      mem_ack   = tl[c].ack_in;
      mem_fault = tl[c].flt_in;
      kill      = tl[c].kill_in;
      cyc       = c;
      chk_en    = 1'b1;
    end
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    start = 0; mem_ack = 0; mem_fault = 0; kill = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_output($sformatf("c%0d mem_req", cyc),    mem_req,    tl[cyc].req);
      check_output($sformatf("c%0d mem_we", cyc),     mem_we,     tl[cyc].we);
      check_output($sformatf("c%0d busy", cyc),       busy,       tl[cyc].bsy);
      check_output($sformatf("c%0d done", cyc),       done,       tl[cyc].dn);
      check_output($sformatf("c%0d fault", cyc),      fault,      tl[cyc].ft);
      check_output($sformatf("c%0d step", cyc),       step,       tl[cyc].stp);
      check_output($sformatf("c%0d ord", cyc),        ord,        tl[cyc].od);
      check_output($sformatf("c%0d fault_step", cyc), fault_step, tl[cyc].fs);
      if (done && done_cyc < 0) done_cyc = cyc;
      if (fault && fault_cyc < 0) fault_cyc = cyc;
      if (mem_req) req_cnt++;
      if (mem_req && mem_we) we_cnt++;
      if (mem_req && !prev_req) req_steps.push_back(int'(step));
      prev_req = mem_req;
    end
  end

  initial begin
    rst = 0; start = 0; kind = 0; is_store = 0; vl = 0; mask = '0;
    kill = 0; mem_ack = 0; mem_fault = 0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset busy", busy, 0);
    check_output("reset mem_req", mem_req, 0);
    check_output("reset step", step, 0);
    check_output("reset ord", ord, 0);
    check_output("reset fault_step", fault_step, 0);
    rst = 1;

    $display("[TB] scalar load, ack after 2 waits");
    build_op(0, 0, 0, 64'hFFFF, 2, -1, -1);
    apply_stimulus(0, 0, 0, 64'hFFFF);
    check_output("scalar done cycle", done_cyc, 5);
    check_output("scalar req cycles", req_cnt, 3);
    check_output("scalar req count", req_steps.size(), 1);

    $display("[TB] vector vl=8 mask=A5");
    build_op(1, 0, 8, 64'h0000_00A5, 0, -1, -1);
    apply_stimulus(1, 0, 8, 64'h0000_00A5);
    check_output("vec req count", req_steps.size(), 4);
    if (req_steps.size() == 4) begin
      check_output("vec step0", req_steps[0], 0);
      check_output("vec step1", req_steps[1], 2);
      check_output("vec step2", req_steps[2], 5);
      check_output("vec step3", req_steps[3], 7);
    end
    check_output("vec done cycle", done_cyc, 9);

    $display("[TB] vector vl=0");
    build_op(1, 0, 0, '1, 0, -1, -1);
    apply_stimulus(1, 0, 0, '1);
    check_output("vl0 done cycle", done_cyc, 1);
    check_output("vl0 req cycles", req_cnt, 0);

    $display("[TB] vector vl=64 full mask, first and last");
    build_op(1, 0, 64, 64'h8000_0000_0000_0001, 0, -1, -1);
    apply_stimulus(1, 0, 64, 64'h8000_0000_0000_0001);
    check_output("vl64 req count", req_steps.size(), 2);

    $display("[TB] multi store 0 and 63");
    build_op(2, 1, 0, 64'h8000_0000_0000_0001, 0, -1, -1);
    apply_stimulus(2, 1, 0, 64'h8000_0000_0000_0001);
    check_output("multi we cycles", we_cnt, 2);
    check_output("multi req count", req_steps.size(), 2);
    if (req_steps.size() == 2) check_output("multi last step", req_steps[1], 63);
    check_output("multi done cycle", done_cyc, 5);

    $display("[TB] vector fault on step 2");
    build_op(1, 0, 4, 64'hF, 0, 2, -1);
    apply_stimulus(1, 0, 4, 64'hF);
    check_output("fault cycle", fault_cyc, 7);
    check_output("fault no done", done_cyc, -1);
    check_output("fault_step", fault_step, 2);

    $display("[TB] kill during REQ, ack after 3 waits");
    build_op(1, 0, 4, 64'h3, 3, -1, 0);
    apply_stimulus(1, 0, 4, 64'h3);
    check_output("kill req cycles", req_cnt, 4);
    check_output("kill no done", done_cyc, -1);
    check_output("kill no fault", fault_cyc, -1);

    $display("[TB] start with kill in IDLE");
    tl.delete();
    tl.push_back(mk(0, 0, 0, 0, 0));
    tl[0].st_in = 1; tl[0].kill_in = 1;
    repeat (3) tl.push_back(mk(0, 0, 0, 0, 0));
    apply_stimulus(2, 0, 0, 64'h1);
    check_output("start+kill no done", done_cyc, -1);

    $display("[TB] async reset mid-REQ");
    kind = 2'd1; vl = 7'd4; mask = 64'hF; is_store = 1;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    @(posedge clk); #3;
    check_output("pre-reset mem_req", mem_req, 1);
    rst = 0;
    #1;
    check_output("async rst mem_req", mem_req, 0);
    check_output("async rst mem_we", mem_we, 0);
    check_output("async rst busy", busy, 0);
    check_output("async rst step", step, 0);
    check_output("async rst fault_step", fault_step, 0);
    @(posedge clk); #1 rst = 1;
    m_step = '0; m_ord = '0; m_fs = '0;

    $display("[TB] recovery vector after reset");
    build_op(1, 0, 3, 64'h6, 1, -1, -1);
    apply_stimulus(1, 0, 3, 64'h6);
    check_output("recover req count", req_steps.size(), 2);
    check_output("recover done cycle", done_cyc, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
